// File: rtl/sb_route_matrix.sv
// Switch-box routing matrix: four sides of W tracks, each output picks the same
// track index from one of the other three sides, under a serially loaded config.

module sb_route_cell (
    input  logic [1:0] sel,
    input  logic [2:0] cand,   // cand[k] = same track on side (s+k+1)%4
    input  logic       en,
    output logic       out,
    output logic       oe
);
    always_comb begin
        out = 1'b0;
        oe  = 1'b0;
        if (en) begin
            case (sel)
                2'b01:   begin out = cand[0]; oe = 1'b1; end
                2'b10:   begin out = cand[1]; oe = 1'b1; end
                2'b11:   begin out = cand[2]; oe = 1'b1; end
                default: begin out = 1'b0;    oe = 1'b0; end
            endcase
        end
    end
endmodule

module sb_route_matrix #(
    parameter int W       = 4,
    parameter int REG_OUT = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           prgm_b,
    input  logic           cfg_bit,
    input  logic           cfg_valid,
    output logic           cfg_done,
    output logic           cfg_err,
    input  logic [4*W-1:0] sb_in,
    output logic [4*W-1:0] sb_out,
    output logic [4*W-1:0] sb_oe
);
    localparam int CFG_BITS = 8 * W;
    localparam int CW       = $clog2(CFG_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CFG_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [CW-1:0]       cnt;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_LOAD: begin
                if (prgm_b) state_n = (cnt == CNT_FULL) ? ST_ACTIVE : ST_ERROR;
            end
            default: begin
                if (!prgm_b) state_n = ST_LOAD;
            end
        endcase
    end

    // Shadow collects the stream; active only changes on a clean window close.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
            cnt    <= '0;
        end else begin
            if (state != ST_LOAD && state_n == ST_LOAD) begin
                shadow <= '0;
                cnt    <= '0;
            end else if (state == ST_LOAD && !prgm_b && cfg_valid) begin
                shadow <= {shadow[CFG_BITS-2:0], cfg_bit};
                if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
            end
            if (state == ST_LOAD && state_n == ST_ACTIVE) active <= shadow;
            if (state == ST_LOAD && state_n == ST_ERROR)  active <= '0;
        end
    end

    assign cfg_done = (state == ST_ACTIVE);
    assign cfg_err  = (state == ST_ERROR);

    logic [4*W-1:0] route_out, route_oe;
    logic           route_en;
    assign route_en = (state == ST_ACTIVE);

    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar t = 0; t < W; t++) begin : g_trk
            sb_route_cell u_cell (
                .sel  (active[2*(s*W+t) +: 2]),
                .cand ({sb_in[((s+3)%4)*W+t], sb_in[((s+2)%4)*W+t], sb_in[((s+1)%4)*W+t]}),
                .en   (route_en),
                .out  (route_out[s*W+t]),
                .oe   (route_oe[s*W+t])
            );
        end
    end

    if (REG_OUT != 0) begin : g_reg
        logic [4*W-1:0] out_q, oe_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                out_q <= '0;
                oe_q  <= '0;
            end else begin
                out_q <= route_out;
                oe_q  <= route_oe;
            end
        end
        assign sb_out = out_q;
        assign sb_oe  = oe_q;
    end else begin : g_comb
        assign sb_out = route_out;
        assign sb_oe  = route_oe;
    end
endmodule

// File: tb/tb_sb_route_matrix.sv
// Directed bench: a combinational and a registered matrix share all inputs.
module tb_sb_route_matrix;
    logic        clk = 0;
    logic        reset, prgm_b, cfg_bit, cfg_valid;
    logic [15:0] sb_in;
    logic        done0, err0, done1, err1;
    logic [15:0] out0, oe0, out1, oe1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    sb_route_matrix #(.W(4), .REG_OUT(0)) u_comb (
        .clk(clk), .reset(reset), .prgm_b(prgm_b), .cfg_bit(cfg_bit),
        .cfg_valid(cfg_valid), .cfg_done(done0), .cfg_err(err0),
        .sb_in(sb_in), .sb_out(out0), .sb_oe(oe0));

    sb_route_matrix #(.W(4), .REG_OUT(1)) u_reg (
        .clk(clk), .reset(reset), .prgm_b(prgm_b), .cfg_bit(cfg_bit),
        .cfg_valid(cfg_valid), .cfg_done(done1), .cfg_err(err1),
        .sb_in(sb_in), .sb_out(out1), .sb_oe(oe1));

    typedef struct {
        logic [31:0] cfg;
        logic [15:0] in;
        logic [15:0] out;
        logic [15:0] oe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Shifts n bits, MSB of cfg first; bits past 32 are zero.
    task automatic load(input logic [31:0] cfg, input int n);
        @(negedge clk);
        prgm_b = 0; cfg_valid = 0;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cfg_valid = 1;
            cfg_bit   = (i < 32) ? cfg[31-i] : 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        cfg_valid = 0; cfg_bit = 0; prgm_b = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[8];
    logic [31:0] cur_cfg;

    initial begin
        reset = 1; prgm_b = 1; cfg_bit = 0; cfg_valid = 0; sb_in = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done", {30'd0, done0, done1}, 32'd0);
        check("rst_err",  {30'd0, err0, err1}, 32'd0);
        check("rst_out",  {out0, out1}, 32'd0);
        check("rst_oe",   {oe0, oe1}, 32'd0);
        reset = 0;

        // N tracks from S (sel=10), then every output from the next side (sel=01)
        vecs[0] = '{32'h000000AA, 16'h0A00, 16'h000A, 16'h000F};
        vecs[1] = '{32'h000000AA, 16'h0500, 16'h0005, 16'h000F};
        vecs[2] = '{32'h000000AA, 16'hF0FF, 16'h0000, 16'h000F};
        vecs[3] = '{32'h000000AA, 16'hFFFF, 16'h000F, 16'h000F};
        vecs[4] = '{32'h55555555, 16'h1234, 16'h4123, 16'hFFFF};
        vecs[5] = '{32'h55555555, 16'hF00F, 16'hFF00, 16'hFFFF};
        vecs[6] = '{32'h55555555, 16'h8001, 16'h1800, 16'hFFFF};
        vecs[7] = '{32'h01020300, 16'h0001, 16'h1110, 16'h1110};
        cur_cfg = 32'hxxxxxxxx;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].cfg !== cur_cfg) begin
                load(vecs[i].cfg, 32);
                check("tbl_done", {31'd0, done0}, 32'd1);
                cur_cfg = vecs[i].cfg;
            end
            sb_in = vecs[i].in;
            #1;
            check($sformatf("tbl_out[%0d]", i), {16'd0, out0}, {16'd0, vecs[i].out});
            check($sformatf("tbl_oe[%0d]", i),  {16'd0, oe0},  {16'd0, vecs[i].oe});
        end

        // short load -> ERROR, then a good load recovers
        load(32'h000000AA, 31);
        check("short_err", {30'd0, err0, done0}, 32'd2);
        check("short_oe", {16'd0, oe0}, 32'd0);
        load(32'h000000AA, 32);
        check("recover", {30'd0, err0, done0}, 32'd1);

        // overlong load saturates the counter -> ERROR
        sb_in = 16'hFFFF;
        load(32'h000000AA, 33);
        check("long_err", {30'd0, err0, done0}, 32'd2);
        check("long_outs", {out0, oe0}, 32'd0);

        // routing drops on LOAD entry; new config only on prgm_b rise
        load(32'h000000AA, 32);
        sb_in = 16'h0A00;
        @(negedge clk);
        prgm_b = 0;
        @(posedge clk); #1;
        check("reload_drop", {15'd0, done0, oe0}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            cfg_valid = 1; cfg_bit = 1'b0 ^ (i % 2 == 1);  // 0101... = 32'h55555555
            @(posedge clk);
        end
        @(negedge clk);
        cfg_valid = 0;
        check("reload_hold", {15'd0, done0, oe0}, 32'd0);
        prgm_b = 1;
        sb_in = 16'h1234;
        @(posedge clk); #1;
        check("reload_new", {out0, oe0}, {16'h4123, 16'hFFFF});

        // reset halfway through a load
        @(negedge clk);
        prgm_b = 0;
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cfg_valid = 1; cfg_bit = 1;
            @(posedge clk);
        end
        @(negedge clk);
        cfg_valid = 0; reset = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 0; prgm_b = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_flags", {28'd0, done0, err0, done1, err1}, 32'd0);
        check("midrst_outs", {out0, oe0}, 32'd0);

        // reset wins over prgm_b=0; no LOAD until reset drops
        reset = 1; prgm_b = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 0; prgm_b = 1;
        @(posedge clk); #1;
        check("rst_vs_prgm", {30'd0, err0, done0}, 32'd0);

        // registered fan-out: N track0 -> E/S/W track0, one clock later
        sb_in = 16'h0000;
        load(32'h01020300, 32);
        @(posedge clk);
        @(negedge clk);
        check("reg_oe", {16'd0, oe1}, 32'h1110);
        check("reg_out0", {16'd0, out1}, 32'h0000);
        sb_in = 16'h0001;
        #1;
        check("reg_lag", {16'd0, out1}, 32'h0000);
        check("comb_fan", {16'd0, out0}, 32'h1110);
        @(posedge clk); #1;
        check("reg_rise", {16'd0, out1}, 32'h1110);
        @(negedge clk);
        sb_in = 16'h0000;
        #1;
        check("reg_hold", {16'd0, out1}, 32'h1110);
        @(posedge clk); #1;
        check("reg_fall", {out1, oe1}, {16'h0000, 16'h1110});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sb_route_matrix.md
Name: sb_route_matrix

Overview:
- Parametrised switch-box routing matrix. Successor to the single 3-terminal switch-box unit.
- Connects W tracks on each of four sides (N/E/S/W) through a disjoint switch pattern.
- Each output track is driven from the same track index on one of the other three sides, or left undriven.
- The routing configuration is loaded serially by a sequential config controller during programming (prgm_b low). It is committed atomically when programming ends.
- Instantiated per tile between CLB connection blocks in the emulator fabric.

Parameters:
- W, 4, tracks per side.
- REG_OUT, 0, 0 = combinational data path; 1 = sb_out/sb_oe registered (1-cycle latency).
- CFG_BITS, 8*W (derived localparam, not overridable), total config bits = 4 sides * W tracks * 2.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset; sampled on rising clk.
- prgm_b  in  1  programming enable, active low; low = config load window.
- cfg_bit  in  1  serial config data.
- cfg_valid  in  1  cfg_bit is sampled on rising clk when high during the load window.
- cfg_done  out  1  high while a valid configuration is active.
- cfg_err  out  1  high after a load window that ended with the wrong bit count.
- sb_in  in  4*W  track inputs; side s, track t at bit s*W+t (s: 0=N, 1=E, 2=S, 3=W).
- sb_out  out  4*W  track outputs, same indexing as sb_in.
- sb_oe  out  4*W  per-track output enable (pad/tristate control upstream).

Behaviour:
- Reset (reset=1 at posedge), regardless of state or prgm_b:
  - state=IDLE; shadow, active config and bit counter cleared.
  - cfg_done=0, cfg_err=0, sb_out=0, sb_oe=0 (registered outputs included).
- Reset mid-load aborts the load; no partial config is committed.
- FSM states: IDLE (unconfigured), LOAD, ACTIVE, ERROR.
- Transitions:
  - IDLE/ACTIVE/ERROR -> LOAD when prgm_b=0 at posedge. On entry: cfg_done=0, cfg_err=0, counter=0, shadow=0.
  - LOAD -> ACTIVE when prgm_b=1 at posedge and count==CFG_BITS. active <= shadow, cfg_done=1 the next cycle.
  - LOAD -> ERROR when prgm_b=1 and count!=CFG_BITS. Active config cleared, cfg_err=1.
  - ACTIVE and ERROR hold until the next prgm_b low or reset.
- Shifting, in LOAD with cfg_valid=1:
  - shadow <= {shadow[CFG_BITS-2:0], cfg_bit}, so the first bit ends at the MSB.
  - Counter increments and saturates at CFG_BITS+1 (overflow then forces ERROR at exit).
  - cfg_valid=0 or cfg_bit=X with cfg_valid=0: no shift.
  - cfg_valid outside LOAD is ignored.
  - The cycle where prgm_b rises does not shift, even with cfg_valid=1.
- Config field for output (s,t): sel = active[2*(s*W+t)+1 : 2*(s*W+t)].
  - 00: off, out=0, oe=0.
  - 01: source side (s+1)%4.
  - 10: source side (s+2)%4.
  - 11: source side (s+3)%4.
  - Source is always track t of the chosen side; for sel!=00, oe=1.
- Output gating:
  - While in LOAD, IDLE or ERROR, all sb_oe=0 and sb_out=0. Previous routing is dropped as soon as the LOAD state is entered.
  - In ACTIVE with REG_OUT=0, sb_out follows sb_in combinationally.
  - With REG_OUT=1, sb_out/sb_oe update one posedge after sb_in or state change.
- Fan-out allowed: one input may drive up to three outputs.
- There is no internal feedback path, so no combinational loop within the block.
- Simultaneous reset and prgm_b=0: reset wins; state IDLE, and LOAD is entered only at a later posedge with reset=0.

Test Plan:
1. W=4, REG_OUT=0. Reset, then prgm_b=0. Shift 32 bits that set every N track sel=10 (from S) and all others 00; raise prgm_b. -> cfg_done=1 one cycle later. sb_in S tracks=4'b1010 gives sb_out N=4'b1010 and sb_oe[3:0]=4'hF; all other sb_oe=0.
2. Load only 31 bits, then raise prgm_b. -> cfg_err=1, cfg_done=0, sb_oe=0. Then a correct 32-bit load gives cfg_err=0 and cfg_done=1.
3. Load 33 bits. -> ERROR (counter saturation), all outputs off.
4. From ACTIVE, drop prgm_b. -> sb_oe goes to 0 immediately on LOAD entry, cfg_done=0. New config commits only on prgm_b rise.
5. Assert reset halfway through a load (16 bits in). -> IDLE, outputs 0. Release reset with prgm_b high: cfg_done and cfg_err stay 0.
6. REG_OUT=1, fan-out config: E, S, W track0 all sel sourcing N track0. Toggle sb_in[0]. -> sb_out bits 4, 8, 12 follow exactly one clk later, all with oe=1.
